// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_t : arbiter mode, ARB (normal arbitration) or LOCK_D (debug owns the bus)
//   owner_t     : which port a registered read return belongs to
//   DEF_AW/DW   : default RAM address and data widths
package mem_arb_pkg;

   localparam int unsigned DEF_AW = 8;
   localparam int unsigned DEF_DW = 16;

   typedef enum logic {
      ARB,
      LOCK_D
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_C,
      OWN_D
   } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter with clear; counts how long the debug port has been refused.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : count one refused cycle (saturates at MAX_WAIT)
//   clr          : clear to zero (wins over inc)
//   cnt          : current count
//   full         : cnt has reached MAX_WAIT
module starve_counter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CW       = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          full
);

   localparam logic [CW-1:0] MaxCnt = CW'(MAX_WAIT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MaxCnt)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign full = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous-read RAM between the CPU (port C) and a debug/loader
// port (port D). CPU has priority unless the CPU is halted or D has been refused MAX_WAIT
// times; D can lock the bus for bursts.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   cpu_halt                          : CPU in HALT, D wins whenever it requests
//   c_req/c_we/c_addr/c_wdata         : CPU request
//   c_gnt, c_rvalid, c_rdata          : CPU grant and read return (one cycle after grant)
//   d_req/d_we/d_addr/d_wdata, d_lock : debug request, d_lock asks for exclusive ownership
//   d_gnt, d_rvalid, d_rdata          : debug grant and read return
//   mem_addr/mem_we/mem_wdata         : RAM request, mem_addr holds when nothing is granted
//   mem_rdata                         : RAM read data, valid one cycle after the address
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW       = DEF_AW,
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cpu_halt,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_lock,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = 4;

   arb_state_t    state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [CW-1:0] wait_cnt;
   logic          wait_full;

   starve_counter #(
      .MAX_WAIT (MAX_WAIT),
      .CW       (CW)
   ) u_starve (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (d_req && !d_gnt),
      .clr     (d_gnt),
      .cnt     (wait_cnt),
      .full    (wait_full)
   );

   // Grants and next state. Grants are also masked by reset_n so nothing is granted
   // while reset is held, even though the requesters may already be asserting.
   always_comb begin
      c_gnt   = 1'b0;
      d_gnt   = 1'b0;
      state_d = state_q;
      if (reset_n) begin
         unique case (state_q)
            ARB: begin
               if (d_req && (cpu_halt || wait_full)) begin
                  d_gnt = 1'b1;
               end else if (c_req) begin
                  c_gnt = 1'b1;
               end else if (d_req) begin
                  d_gnt = 1'b1;
               end
               if (d_gnt && d_lock) begin
                  state_d = LOCK_D;
               end
            end
            LOCK_D: begin
               // cpu_halt is irrelevant here; only dropping d_lock releases the bus
               d_gnt = d_req;
               if (!d_lock) begin
                  state_d = ARB;
               end
            end
            default: state_d = ARB;
         endcase
      end
   end

   // RAM request mux; address and data hold their last value between grants
   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = 1'b0;
      owner_d   = OWN_NONE;
      if (c_gnt) begin
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
         mem_we    = c_we;
         owner_d   = c_we ? OWN_NONE : OWN_C;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_we    = d_we;
         owner_d   = d_we ? OWN_NONE : OWN_D;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB;
         owner_q <= OWN_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
      end
   end

   assign c_rvalid = (owner_q == OWN_C);
   assign d_rvalid = (owner_q == OWN_D);
   assign c_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_halt;
   logic        c_req, c_we;
   logic [7:0]  c_addr;
   logic [15:0] c_wdata;
   logic        c_gnt, c_rvalid;
   logic [15:0] c_rdata;
   logic        d_req, d_we, d_lock;
   logic [7:0]  d_addr;
   logic [15:0] d_wdata;
   logic        d_gnt, d_rvalid;
   logic [15:0] d_rdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int n_pass  = 0;
   int n_total = 0;

   mem_port_arbiter #(
      .AW       (8),
      .DW       (16),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_halt  (cpu_halt),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_gnt     (c_gnt),
      .c_rvalid  (c_rvalid),
      .c_rdata   (c_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_lock    (d_lock),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // The RAM the arbiter fronts: synchronous read, write on mem_we
   logic [15:0] ram [256];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] mmem [256];
   int          refused;
   bit          locked;
   bit          exp_crv, exp_drv;
   logic [15:0] exp_crd, exp_drd;
   logic [7:0]  last_addr;
   logic [15:0] last_wdata;

   always @(negedge clk) begin
      bit          gc, gd, wr;
      logic [7:0]  a;
      logic [15:0] wd;
      if (!reset_n) begin
         chk("m_rst_c_gnt", c_gnt, 0);
         chk("m_rst_d_gnt", d_gnt, 0);
         chk("m_rst_c_rvalid", c_rvalid, 0);
         chk("m_rst_d_rvalid", d_rvalid, 0);
         chk("m_rst_mem_we", mem_we, 0);
         chk("m_rst_mem_addr", mem_addr, 0);
         chk("m_rst_mem_wdata", mem_wdata, 0);
         refused = 0; locked = 0; exp_crv = 0; exp_drv = 0;
         last_addr = 0; last_wdata = 0;
      end else begin
         chk("m_c_rvalid", c_rvalid, exp_crv);
         chk("m_d_rvalid", d_rvalid, exp_drv);
         if (exp_crv) chk("m_c_rdata", c_rdata, exp_crd);
         if (exp_drv) chk("m_d_rdata", d_rdata, exp_drd);
         gc = 0; gd = 0;
         if (locked) gd = d_req;
         else if (d_req && (cpu_halt || refused >= MAX_WAIT)) gd = 1;
         else if (c_req) gc = 1;
         else if (d_req) gd = 1;
         chk("m_c_gnt", c_gnt, gc);
         chk("m_d_gnt", d_gnt, gd);
         wr = (gc && c_we) || (gd && d_we);
         a  = gc ? c_addr : (gd ? d_addr : last_addr);
         wd = gc ? c_wdata : d_wdata;
         chk("m_mem_we", mem_we, wr);
         chk("m_mem_addr", mem_addr, a);
         if (wr) chk("m_mem_wdata", mem_wdata, wd);
         // state after the coming edge
         exp_crv = gc && !c_we;
         exp_drv = gd && !d_we;
         if (exp_crv || exp_drv) begin
            exp_crd = mmem[a];
            exp_drd = mmem[a];
         end
         if (wr) mmem[a] = wd;
         last_addr = a;
         if (gd) refused = 0;
         else if (d_req && refused < MAX_WAIT) refused++;
         if (!locked && gd && d_lock) locked = 1;
         else if (locked && !d_lock) locked = 0;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] dpat, cpat;
      for (int i = 0; i < 256; i++) begin
         ram[i]  = 16'h0;
         mmem[i] = 16'h0;
      end
      ram[25]  = 16'hFFE9;
      mmem[25] = 16'hFFE9;
      reset_n = 0; cpu_halt = 0;
      c_req = 1; c_we = 0; c_addr = 8'd0; c_wdata = 16'h0;
      d_req = 1; d_we = 0; d_addr = 8'd1; d_wdata = 16'h0; d_lock = 0;

      // reset held with both ports requesting
      repeat (2) @(negedge clk);
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      step();
      reset_n = 1;

      // starvation: four C grants, then D on the fifth, repeating
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         dpat[i] = d_gnt;
         cpat[i] = c_gnt;
      end
      chk("starve_first_c", cpat[0], 1);
      chk("starve_d_pattern", dpat, 10'h210);
      chk("starve_c_pattern", cpat, 10'h1EF);

      // C read of mem[25]
      step();
      c_req = 1; c_we = 0; c_addr = 8'd25; d_req = 0;
      @(negedge clk);
      chk("cread_gnt", c_gnt, 1);
      step();
      c_req = 0;
      @(negedge clk);
      chk("cread_rvalid", c_rvalid, 1);
      chk("cread_rdata", c_rdata, 16'hFFE9);
      chk("cread_d_rvalid", d_rvalid, 0);

      // halt priority
      step();
      cpu_halt = 1; c_req = 1; c_addr = 8'd5; d_req = 1; d_we = 0; d_addr = 8'd25;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halt_d_gnt", d_gnt, 1);
         chk("halt_c_gnt", c_gnt, 0);
         step();
      end

      // locked burst of three D writes with C waiting
      cpu_halt = 0; c_req = 0;
      d_req = 1; d_we = 1; d_lock = 1; d_addr = 8'd10; d_wdata = 16'h0011;
      @(negedge clk);
      chk("burst0_d_gnt", d_gnt, 1);
      step();
      c_req = 1; c_we = 0; c_addr = 8'd10;
      d_addr = 8'd11; d_wdata = 16'h0022;
      @(negedge clk);
      chk("burst1_c_gnt", c_gnt, 0);
      chk("burst1_d_gnt", d_gnt, 1);
      step();
      d_addr = 8'd12; d_wdata = 16'h0033; d_lock = 0;
      @(negedge clk);
      chk("burst2_c_gnt", c_gnt, 0);
      chk("burst2_d_gnt", d_gnt, 1);
      step();
      d_req = 0; d_we = 0;
      @(negedge clk);
      chk("unlock_c_gnt", c_gnt, 1);
      step();
      c_addr = 8'd11;
      @(negedge clk);
      chk("rb10", c_rdata, 16'h0011);
      step();
      c_addr = 8'd12;
      @(negedge clk);
      chk("rb11", c_rdata, 16'h0022);
      step();
      c_req = 0;
      @(negedge clk);
      chk("rb12_valid", c_rvalid, 1);
      chk("rb12", c_rdata, 16'h0033);

      // reset while locked with a D read in flight
      step();
      d_req = 1; d_we = 0; d_lock = 1; d_addr = 8'd10;
      @(negedge clk);
      chk("lk_d_gnt", d_gnt, 1);
      step();
      d_addr = 8'd11;
      @(negedge clk);
      chk("lk_d_rvalid", d_rvalid, 1);
      chk("lk_d_rdata", d_rdata, 16'h0011);
      step();
      reset_n = 0; d_req = 0; d_lock = 0;
      @(negedge clk);
      chk("mrst_d_rvalid", d_rvalid, 0);
      step();
      reset_n = 1;
      c_req = 1; c_we = 0; c_addr = 8'd12; d_req = 1; d_addr = 8'd11;
      @(negedge clk);
      chk("mrst_c_gnt", c_gnt, 1);
      chk("mrst_d_gnt", d_gnt, 0);
      chk("mrst_d_rvalid2", d_rvalid, 0);
      step();
      c_req = 0;
      @(negedge clk);
      chk("post_d_gnt", d_gnt, 1);
      chk("post_c_rdata", c_rdata, 16'h0033);
      step();
      d_req = 0;
      @(negedge clk);
      chk("post_d_rdata", d_rdata, 16'h0022);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
